// File: rtl/multi_mode_packer_if.sv
// Purpose: upstream beat, config bus and downstream vector signals of the multi-mode packer.
// Latency: none, wiring only.
// Backpressure: ready_out toward the beat source, ready_in from the downstream consumer.
interface multi_mode_packer_if #(
    parameter int N          = 8,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_CHAINS = 4
);
    localparam int CW  = $clog2(N + 1);
    localparam int CHW = $clog2(MAX_CHAINS);

    logic                           tracing;
    logic                           valid_in;
    logic                           ready_out;
    logic                           eof_in;
    logic [CHW-1:0]                 chainId_in;
    logic [N-1:0][DATA_WIDTH-1:0]   vector_in;
    logic [7:0]                     configId;
    logic [7:0]                     configData;
    logic [N-1:0][DATA_WIDTH-1:0]   vector_out;
    logic [CW-1:0]                  count_out;
    logic                           eof_out;
    logic                           valid_out;
    logic                           ready_in;

    // Beat source / firmware side.
    modport master (
        output tracing, valid_in, eof_in, chainId_in, vector_in, configId, configData, ready_in,
        input  ready_out, vector_out, count_out, eof_out, valid_out
    );

    // Packer side.
    modport slave (
        input  tracing, valid_in, eof_in, chainId_in, vector_in, configId, configData, ready_in,
        output ready_out, vector_out, count_out, eof_out, valid_out
    );
endinterface

// File: rtl/multi_mode_packer.sv
// Purpose: packs N/M/1-lane beats gap-free into N-lane vectors, with eof flush and firmware beat widths.
// Latency: 1 cycle from an accepting edge to valid_out; eof with overflow adds one FLUSH bubble.
// Backpressure: ready_out = PACK & (!valid_out | ready_in); output fields hold while stalled.
module multi_mode_packer #(
    parameter int N                  = 8,
    parameter int M                  = 2,
    parameter int DATA_WIDTH         = 32,
    parameter int MAX_CHAINS         = 4,
    parameter int PERSONAL_CONFIG_ID = 0,
    parameter logic [MAX_CHAINS-1:0][7:0] INITIAL_FIRMWARE = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    multi_mode_packer_if.slave    bus
);
    localparam int CW  = $clog2(N + 1);
    localparam int CHW = $clog2(MAX_CHAINS);
    localparam int MW  = $clog2(2 * N - 1);

    typedef enum logic {PACK, FLUSH} state_e;

    state_e                          state_q, state_d;
    logic [CW-1:0]                   c_q, c_d;
    logic [N-2:0][DATA_WIDTH-1:0]    acc_q, acc_d;
    logic [N-1:0][DATA_WIDTH-1:0]    vout_q, vout_d;
    logic [CW-1:0]                   cnt_q, cnt_d;
    logic                            eof_q, eof_d;
    logic                            vld_q, vld_d;
    logic [MAX_CHAINS-1:0][7:0]      fw_q;
    logic [CHW-1:0]                  ptr_q;

    logic                            out_free;
    logic                            ready;
    logic                            accept;
    logic [7:0]                      fw_sel;
    int                              l_int;
    int                              c_int;
    int                              t_int;
    logic [2*N-2:0][DATA_WIDTH-1:0]  merged;

    assign out_free = !vld_q || bus.ready_in;
    assign ready    = (state_q == PACK) && out_free;
    assign accept   = bus.valid_in && ready && bus.tracing;

    assign bus.ready_out  = ready;
    assign bus.vector_out = vout_q;
    assign bus.count_out  = cnt_q;
    assign bus.eof_out    = eof_q;
    assign bus.valid_out  = vld_q;

    // Append the incoming beat's lanes directly after the held residual.
    always_comb begin
        fw_sel = fw_q[bus.chainId_in];
        if (fw_sel == 8'd0)      l_int = N;
        else if (fw_sel == 8'd1) l_int = M;
        else                     l_int = 1;
        c_int  = int'(c_q);
        t_int  = c_int + l_int;
        merged = '0;
        for (int i = 0; i < N - 1; i++) begin
            if (i < c_int) merged[i] = acc_q[i];
        end
        for (int j = 0; j < N; j++) begin
            if (j < l_int) merged[MW'(c_int + j)] = bus.vector_in[j];
        end
    end

    // Emission decision, residual update and FSM next state.
    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        acc_d   = acc_q;
        vout_d  = vout_q;
        cnt_d   = cnt_q;
        eof_d   = eof_q;
        vld_d   = vld_q && !bus.ready_in;
        case (state_q)
            PACK: begin
                if (accept) begin
                    if (t_int < N) begin
                        if (bus.eof_in) begin
                            vout_d = merged[N-1:0];
                            cnt_d  = CW'(t_int);
                            eof_d  = 1'b1;
                            vld_d  = 1'b1;
                            c_d    = '0;
                            acc_d  = '0;
                        end else begin
                            c_d   = CW'(t_int);
                            acc_d = merged[N-2:0];
                        end
                    end else if (t_int == N) begin
                        vout_d = merged[N-1:0];
                        cnt_d  = CW'(N);
                        eof_d  = bus.eof_in;
                        vld_d  = 1'b1;
                        c_d    = '0;
                        acc_d  = '0;
                    end else begin
                        // Overflow: the tail stays behind; with eof it leaves next via FLUSH.
                        vout_d = merged[N-1:0];
                        cnt_d  = CW'(N);
                        eof_d  = 1'b0;
                        vld_d  = 1'b1;
                        c_d    = CW'(t_int - N);
                        acc_d  = merged[2*N-2:N];
                        if (bus.eof_in) state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (out_free) begin
                    vout_d  = {{DATA_WIDTH{1'b0}}, acc_q};
                    cnt_d   = c_q;
                    eof_d   = 1'b1;
                    vld_d   = 1'b1;
                    c_d     = '0;
                    acc_d   = '0;
                    state_d = PACK;
                end
            end
            default: state_d = PACK;
        endcase
    end

    // Packing state and output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= PACK;
            c_q     <= '0;
            acc_q   <= '0;
            vout_q  <= '0;
            cnt_q   <= '0;
            eof_q   <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            acc_q   <= acc_d;
            vout_q  <= vout_d;
            cnt_q   <= cnt_d;
            eof_q   <= eof_d;
            vld_q   <= vld_d;
        end
    end

    // Firmware table written round-robin from the config bus; beats see it a cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fw_q  <= INITIAL_FIRMWARE;
            ptr_q <= '0;
        end else if (bus.configId == 8'(PERSONAL_CONFIG_ID)) begin
            fw_q[ptr_q] <= bus.configData;
            ptr_q       <= (ptr_q == CHW'(MAX_CHAINS - 1)) ? '0 : ptr_q + 1'b1;
        end
    end
endmodule

// File: tb/tb_multi_mode_packer.sv
// Purpose: randomized and directed bench for multi_mode_packer against a lane-queue reference model.
// Latency: checks outputs every cycle just after driving inputs at the falling edge.
// Backpressure: ready_in is driven randomly; ready_out is predicted from the model's pending vectors.
module tb_multi_mode_packer;
    localparam int N  = 8;
    localparam int M  = 2;
    localparam int DW = 32;
    localparam int MC = 4;
    localparam int VW = N * DW;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    multi_mode_packer_if #(.N(N), .DATA_WIDTH(DW), .MAX_CHAINS(MC)) bus ();

    multi_mode_packer #(
        .N(N), .M(M), .DATA_WIDTH(DW), .MAX_CHAINS(MC), .PERSONAL_CONFIG_ID(0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [VW-1:0] v;
        int            cnt;
        bit            eof;
    } exp_t;

    exp_t         outq[$];
    logic [DW-1:0] pend[$];
    logic [7:0]   fw[MC];
    int           ptr;
    int           n_vec = 0;
    int           n_err = 0;

    task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        outq.delete();
        pend.delete();
        for (int i = 0; i < MC; i++) fw[i] = 8'd0;
        ptr = 0;
    endtask

    // Move up to N oldest pending lanes into one expected output vector.
    task automatic push_chunk(input bit frame_end);
        exp_t e;
        int   n;
        n   = (pend.size() < N) ? pend.size() : N;
        e.v = '0;
        for (int k = 0; k < n; k++) e.v[k*DW +: DW] = pend.pop_front();
        e.cnt = n;
        e.eof = frame_end && (pend.size() == 0);
        outq.push_back(e);
    endtask

    task automatic idle_inputs();
        bus.tracing    = 1'b1;
        bus.valid_in   = 1'b0;
        bus.eof_in     = 1'b0;
        bus.chainId_in = '0;
        bus.vector_in  = '0;
        bus.configId   = 8'hA5;
        bus.configData = 8'h00;
        bus.ready_in   = 1'b1;
    endtask

    // One clock: drive, check DUT against model, then advance the model past the rising edge.
    task automatic cycle(input bit vld, input bit eof, input bit trc, input bit rdy, input int chain,
                         input logic [VW-1:0] data, input logic [7:0] cid, input logic [7:0] cdat);
        bit exp_rdy;
        bit acc;
        int L;
        @(negedge clk);
        bus.valid_in   = vld;
        bus.eof_in     = eof;
        bus.tracing    = trc;
        bus.ready_in   = rdy;
        bus.chainId_in = 2'(chain);
        bus.vector_in  = data;
        bus.configId   = cid;
        bus.configData = cdat;
        #1;
        exp_rdy = (outq.size() == 0) || (outq.size() == 1 && rdy);
        check("ready_out", VW'(bus.ready_out), VW'(exp_rdy));
        check("valid_out", VW'(bus.valid_out), VW'(outq.size() != 0));
        if (outq.size() != 0) begin
            check("vector_out", bus.vector_out, outq[0].v);
            check("count_out", VW'(bus.count_out), VW'(outq[0].cnt));
            check("eof_out", VW'(bus.eof_out), VW'(outq[0].eof));
        end
        acc = vld && exp_rdy && trc;
        if (rdy && outq.size() != 0) void'(outq.pop_front());
        if (acc) begin
            L = (fw[chain] == 8'd0) ? N : (fw[chain] == 8'd1) ? M : 1;
            for (int j = 0; j < L; j++) pend.push_back(data[j*DW +: DW]);
            if (eof) begin
                while (pend.size() != 0) push_chunk(1'b1);
            end else begin
                while (pend.size() >= N) push_chunk(1'b0);
            end
        end
        if (cid == 8'd0) begin
            fw[ptr] = cdat;
            ptr     = (ptr + 1) % MC;
        end
    endtask

    function automatic logic [VW-1:0] ramp(input int base);
        logic [VW-1:0] d;
        for (int i = 0; i < N; i++) d[i*DW +: DW] = DW'(base + i);
        return d;
    endfunction

    task automatic beat(input int chain, input int base, input bit eof, input bit rdy);
        cycle(1'b1, eof, 1'b1, rdy, chain, ramp(base), 8'hA5, 8'h00);
    endtask

    task automatic cfg(input logic [7:0] val);
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 0, '0, 8'h00, val);
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b1, rdy, 0, '0, 8'hA5, 8'h00);
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b0;
        #1;
        check("rst_valid", VW'(bus.valid_out), '0);
        check("rst_vector", bus.vector_out, '0);
        check("rst_count", VW'(bus.count_out), '0);
        check("rst_eof", VW'(bus.eof_out), '0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [VW-1:0] want;
        logic [VW-1:0] rd;
        idle_inputs();
        model_reset();
        rst_n = 1'b0;
        do_reset();

        // All chains medium width; four beats 1..8 give exactly one full vector.
        for (int i = 0; i < 4; i++) cfg(8'd1);
        for (int i = 0; i < 4; i++) beat(0, 2 * i + 1, 1'b0, 1'b1);
        idle(1, 1'b0);
        want = ramp(1);
        check("t1_vector_1to8", bus.vector_out, want);
        idle(1, 1'b1);

        // chain0 single lane, chain1 full width: 1 | 10..17 | 20..27.
        cfg(8'd2);
        cfg(8'd0);
        beat(0, 1, 1'b0, 1'b1);
        beat(1, 10, 1'b0, 1'b1);
        beat(1, 20, 1'b0, 1'b1);
        // Six single lanes bring the residual to 7, then a full beat with eof overflows into FLUSH.
        for (int i = 0; i < 6; i++) beat(0, 30 + i, 1'b0, 1'b1);
        beat(1, 40, 1'b1, 1'b1);
        idle(3, 1'b1);

        // Stall while full: beats are offered during 5 cycles of ready_in low.
        beat(1, 50, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) beat(1, 60, 1'b0, 1'b0);
        beat(1, 70, 1'b0, 1'b1);
        idle(2, 1'b1);

        // Partial frame of medium beats closed by eof: six lanes plus zero padding.
        cfg(8'd1);
        cfg(8'd2);
        for (int i = 0; i < 3; i++) beat(2, 2 * i + 1, i == 2, 1'b1);
        idle(2, 1'b1);

        // Round-robin writes wrap the pointer; each chain then shows its width.
        cfg(8'd1); cfg(8'd2); cfg(8'd0); cfg(8'd1);
        for (int c = 0; c < MC; c++) beat(c, 100 + 10 * c, 1'b0, 1'b1);
        cfg(8'd0);
        beat(0, 200, 1'b1, 1'b1);
        idle(2, 1'b1);

        // Beats while tracing is low are dropped.
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 1'b1, 2, ramp(300), 8'hA5, 8'h00);
        idle(1, 1'b1);

        // Reset mid-frame: residual discarded, firmware back to full width.
        beat(1, 400, 1'b0, 1'b1);
        beat(0, 410, 1'b0, 1'b0);
        do_reset();
        beat(0, 500, 1'b1, 1'b1);
        idle(1, 1'b0);
        want = ramp(500);
        check("post_reset_lane0", bus.vector_out, want);
        idle(1, 1'b1);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < N; i++) rd[i*DW +: DW] = $urandom;
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0,
                  $urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0,
                  int'($urandom_range(0, MC - 1)), rd,
                  ($urandom_range(0, 15) == 0) ? 8'h00 : 8'hA5, 8'($urandom_range(0, 3)));
        end
        idle(4, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
